timer_host: RTL and testbench

//  Initiator for the 8-bit byte-wide timer register interface. It takes a 16-bit reload

---
 rtl/timer_host_pkg.sv | 33 +++
 rtl/timer_irq_tracker.sv | 58 +++++
 rtl/timer_host.sv | 170 +++++++++++++++++
 tb/tb_timer_host.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_host_pkg.sv
// Shared types and control-byte layout for the timer register initiator.
package timer_host_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_LO  = 3'd1,
        WR_HI  = 3'd2,
        RD_LO  = 3'd3,
        RD_HI  = 3'd4,
        COMMIT = 3'd5
    } state_t;

    localparam int CTRL_SEG        = 0;
    localparam int CTRL_WE         = 1;
    localparam int CTRL_INTEN      = 2;
    localparam int CTRL_PERIOD_LSB = 3;

    function automatic logic [7:0] pack_control(input logic [4:0] period, input logic int_en,
                                                input logic we, input logic seg);
        logic [7:0] c;
        c                  = 8'h00;
        c[7:CTRL_PERIOD_LSB] = period;
        c[CTRL_INTEN]      = int_en;
        c[CTRL_WE]         = we;
        c[CTRL_SEG]        = seg;
        return c;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [15:0] value, input logic seg);
        return seg ? value[15:8] : value[7:0];
    endfunction

endpackage

// File: rtl/timer_irq_tracker.sv
// Interrupt edge detector with sticky pending flag; optional saturating edge
// counter built only when TIMER_HOST_IRQ_COUNT_EN is defined.
module timer_irq_tracker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        interrupt,
    input  logic        irq_ack,
`ifdef TIMER_HOST_IRQ_COUNT_EN
    input  logic        count_clr,
    output logic [15:0] irq_count,
`endif
    output logic        irq_pending
);

    logic prev_r;
    logic pending_r;
    logic rise_s;

    assign rise_s      = interrupt & ~prev_r;
    assign irq_pending = pending_r;

    // Edge history and sticky flag; a new edge beats a same-cycle ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r    <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            prev_r <= interrupt;
            if (rise_s) begin
                pending_r <= 1'b1;
            end else if (irq_ack) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

`ifdef TIMER_HOST_IRQ_COUNT_EN
    logic [15:0] count_r;

    assign irq_count = count_r;

    // Saturating edge counter, cleared by a newly accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 16'h0000;
        end else if (count_clr) begin
            count_r <= 16'h0000;
        end else if (rise_s && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'h0001;
        end else begin
            count_r <= count_r;
        end
    end
`endif

endmodule

// File: rtl/timer_host.sv
// Loads a 16-bit reload into the byte-wide timer, verifies it by readback and commits it.
// Define TIMER_HOST_IRQ_COUNT_EN to add the irq_count port.
module timer_host
    import timer_host_pkg::*;
#(
    parameter int PERIOD_W  = 5,
    parameter int MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [15:0]         req_value,
    input  logic [PERIOD_W-1:0] req_period,
    input  logic                req_int_en,
    output logic                done,
    output logic                err,
    output logic [7:0]          control,
    output logic [7:0]          set,
    input  logic [7:0]          read,
    input  logic                interrupt,
    output logic                irq_pending,
`ifdef TIMER_HOST_IRQ_COUNT_EN
    output logic [15:0]         irq_count,
`endif
    input  logic                irq_ack
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t               state_r, state_s;
    logic [15:0]          val_r, val_n_s;
    logic [PERIOD_W-1:0]  period_r, period_n_s, cfg_period_r, cfg_period_n_s, ctrl_period_s;
    logic                 int_en_r, int_en_n_s, cfg_int_en_r, cfg_int_en_n_s, ctrl_int_en_s;
    logic [RETRY_W-1:0]   retry_r;
    logic                 mismatch_r, hold_r;
    logic                 accept_s, fail_s, can_retry_s, retry_go_s, give_up_s;
    logic                 seg_s, we_s;
    logic [7:0]           control_r, set_r;
    logic                 done_r, err_r, ready_r;

    assign accept_s    = req_valid && (state_r == IDLE);
    assign fail_s      = mismatch_r || (read != pick_byte(val_r, 1'b1));
    assign can_retry_s = (retry_r < RETRY_W'(MAX_RETRY));
    assign retry_go_s  = (state_r == RD_HI) && fail_s && can_retry_s;
    assign give_up_s   = (state_r == RD_HI) && fail_s && !can_retry_s;

    assign val_n_s        = accept_s ? req_value : val_r;
    assign period_n_s     = accept_s ? req_period : period_r;
    assign int_en_n_s     = accept_s ? req_int_en : int_en_r;
    assign cfg_period_n_s = (state_r == COMMIT) ? period_r : cfg_period_r;
    assign cfg_int_en_n_s = (state_r == COMMIT) ? int_en_r : cfg_int_en_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a retried pass lingers one extra cycle in WR_LO
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? WR_LO : IDLE;
            WR_LO:   state_s = hold_r ? WR_LO : WR_HI;
            WR_HI:   state_s = RD_LO;
            RD_LO:   state_s = RD_HI;
            RD_HI: begin
                if (!fail_s) begin
                    state_s = COMMIT;
                end else if (can_retry_s) begin
                    state_s = WR_LO;
                end else begin
                    state_s = IDLE;
                end
            end
            COMMIT:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode for the upcoming state; IDLE shows the committed config
    always_comb begin
        seg_s         = 1'b0;
        we_s          = 1'b0;
        ctrl_period_s = period_n_s;
        ctrl_int_en_s = int_en_n_s;
        case (state_s)
            IDLE: begin
                ctrl_period_s = cfg_period_n_s;
                ctrl_int_en_s = cfg_int_en_n_s;
            end
            WR_HI, RD_HI: seg_s = 1'b1;
            COMMIT:       we_s  = 1'b1;
            default:      seg_s = 1'b0;
        endcase
    end

    // Registered interface outputs, aligned with state_r
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            control_r <= 8'h00;
            set_r     <= 8'h00;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            control_r <= pack_control(ctrl_period_s, ctrl_int_en_s, we_s, seg_s);
            set_r     <= pick_byte(val_n_s, seg_s);
            done_r    <= (state_r == COMMIT);
            err_r     <= give_up_s;
            ready_r   <= (state_s == IDLE);
        end
    end

    // Latched request, committed config, retry bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_r        <= 16'h0000;
            period_r     <= '0;
            int_en_r     <= 1'b0;
            cfg_period_r <= '0;
            cfg_int_en_r <= 1'b0;
            retry_r      <= '0;
            mismatch_r   <= 1'b0;
            hold_r       <= 1'b0;
        end else begin
            val_r        <= val_n_s;
            period_r     <= period_n_s;
            int_en_r     <= int_en_n_s;
            cfg_period_r <= cfg_period_n_s;
            cfg_int_en_r <= cfg_int_en_n_s;
            hold_r       <= retry_go_s;
            if (accept_s) begin
                retry_r <= '0;
            end else if (retry_go_s) begin
                retry_r <= retry_r + RETRY_W'(1);
            end else begin
                retry_r <= retry_r;
            end
            if (state_r == RD_LO) begin
                mismatch_r <= (read != pick_byte(val_r, 1'b0));
            end else begin
                mismatch_r <= mismatch_r;
            end
        end
    end

    assign control   = control_r;
    assign set       = set_r;
    assign done      = done_r;
    assign err       = err_r;
    assign req_ready = ready_r;

    timer_irq_tracker u_irq (
        .clk         (clk),
        .rst_n       (rst_n),
        .interrupt   (interrupt),
        .irq_ack     (irq_ack),
`ifdef TIMER_HOST_IRQ_COUNT_EN
        .count_clr   (accept_s),
        .irq_count   (irq_count),
`endif
        .irq_pending (irq_pending)
    );

endmodule

// File: tb/tb_timer_host.sv
// Scoreboard bench for timer_host with a behavioural byte-wide timer and readback corruption.
module tb_timer_host;

    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_value = 16'h0;
    logic [4:0]  req_period = 5'h0;
    logic        req_int_en = 1'b0;
    logic        done, err;
    logic [7:0]  control, set, read;
    logic        interrupt = 1'b0;
    logic        irq_pending;
    logic        irq_ack = 1'b0;
`ifdef TIMER_HOST_IRQ_COUNT_EN
    logic [15:0] irq_count;
`endif

    timer_host #(.PERIOD_W(5), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_value(req_value), .req_period(req_period), .req_int_en(req_int_en),
        .done(done), .err(err), .control(control), .set(set), .read(read),
        .interrupt(interrupt), .irq_pending(irq_pending),
`ifdef TIMER_HOST_IRQ_COUNT_EN
        .irq_count(irq_count),
`endif
        .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural timer: captures set into the seg byte when we=0, copies to resetVal when we=1
    logic [15:0] tm_set = 16'h0;
    logic [15:0] tm_reset = 16'h0;
    int          we_count = 0;
    always @(posedge clk) begin
        if (control[1]) begin
            tm_reset <= tm_set;
            we_count <= we_count + 1;
        end else if (control[0]) begin
            tm_set[15:8] <= set;
        end else begin
            tm_set[7:0] <= set;
        end
    end

    // readback corruption for the first fp_cur passes (5 cycles each)
    logic       in_txn = 1'b0;
    int         fp_cur = 0;
    logic       cseg_cur = 1'b0;
    logic [7:0] mask_cur = 8'h00;
    logic       zero_cur = 1'b0;
    int         n_s;
    logic [7:0] true_rd;
    assign n_s     = cyc - acc;
    assign true_rd = control[0] ? tm_set[15:8] : tm_set[7:0];
    assign read = (in_txn && zero_cur && n_s == 3) ? 8'h00 :
                  (in_txn && n_s >= 1 && n_s <= fp_cur * 5 - 1 && control[0] == cseg_cur) ?
                  (true_rd ^ mask_cur) : true_rd;

    typedef struct {
        logic        is_err;
        int          lat;
        logic [15:0] commit_val;
        logic [7:0]  idle_ctrl;
        logic [7:0]  lo;
        int          we_total;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] ref_commit = 16'h0;
    logic [5:0]  ref_cfg = 6'h0;
    int          ref_we = 0;
    logic        prev_m = 1'b0;
    logic        pend_m = 1'b0;
    logic [15:0] cnt_m = 16'h0;

    // monitor: pops one expectation per done/err pulse
    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            if (exp_q.size() == 0) begin
                chk("spurious_response", {30'd0, done, err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_kind", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
                chk("latency", 32'(cyc - acc), 32'(e.lat));
                chk("timer_reset_val", {16'd0, tm_reset}, {16'd0, e.commit_val});
                chk("idle_control", {24'd0, control}, {24'd0, e.idle_ctrl});
                chk("idle_set", {24'd0, set}, {24'd0, e.lo});
                chk("ready_after", {31'd0, req_ready}, 32'd1);
                chk("we_pulses", 32'(we_count), 32'(e.we_total));
            end
        end
    end

    task automatic run_txn(input logic [15:0] v, input logic [4:0] p, input logic ie, input int fp,
                           input logic cseg, input logic [7:0] mask, input logic zero_first,
                           input logic trace);
        exp_t e;
        int   f;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_value = v; req_period = p; req_int_en = ie;
        acc = cyc; fp_cur = fp; cseg_cur = cseg; mask_cur = mask; zero_cur = zero_first;
        in_txn = 1'b1;
        f = zero_first ? 1 : fp;
        if (f > MAX_RETRY) begin
            e.is_err = 1'b1;
            e.lat    = 5 * (MAX_RETRY + 1);
        end else begin
            e.is_err   = 1'b0;
            e.lat      = 6 + 5 * f;
            ref_commit = v;
            ref_cfg    = {p, ie};
            ref_we++;
        end
        e.commit_val = ref_commit;
        e.idle_ctrl  = {ref_cfg, 2'b00};
        e.lo         = v[7:0];
        e.we_total   = ref_we;
        exp_q.push_back(e);
`ifdef TIMER_HOST_IRQ_COUNT_EN
        cnt_m = 16'h0;
`endif
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n <= 3) begin
                req_valid = 1'b1; req_value = 16'($urandom); req_period = 5'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            if (trace) begin
                logic seg, we;
                seg = (n == 2) || (n == 4);
                we  = (n == 5);
                chk($sformatf("ctrl_c%0d", n), {24'd0, control}, {24'd0, p, ie, we, seg});
                chk($sformatf("set_c%0d", n), {24'd0, set}, {24'd0, seg ? v[15:8] : v[7:0]});
            end
        end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("response_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        in_txn = 1'b0; zero_cur = 1'b0; fp_cur = 0;
    endtask

    task automatic irq_step(input logic intr, input logic ack);
        interrupt = intr; irq_ack = ack;
        if (intr && !prev_m) begin
            pend_m = 1'b1;
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'h1;
        end else if (ack) begin
            pend_m = 1'b0;
        end
        prev_m = intr;
        @(negedge clk);
        chk("irq_pending", {31'd0, irq_pending}, {31'd0, pend_m});
`ifdef TIMER_HOST_IRQ_COUNT_EN
        chk("irq_count", {16'd0, irq_count}, {16'd0, cnt_m});
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_control", {24'd0, control}, 32'h0);
        chk("rst_set", {24'd0, set}, 32'h0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_irq", {31'd0, irq_pending}, 32'd0);

        run_txn(16'hA55A, 5'd3, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1);
        run_txn(16'h3C96, 5'd7, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_txn(16'h1234, 5'd9, 1'b1, 99, 1'b1, 8'hFF, 1'b0, 1'b0);

        irq_step(1'b1, 1'b1);
        irq_step(1'b0, 1'b0);
        irq_step(1'b0, 1'b1);
        irq_step(1'b1, 1'b0);
        irq_step(1'b1, 1'b1);
        for (int i = 0; i < 30; i++) irq_step(1'($urandom), 1'($urandom));
        irq_step(1'b0, 1'b1);

        // async reset while the high byte is being written
        req_valid = 1'b1; req_value = 16'hBEEF; req_period = 5'd21; req_int_en = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_control", {24'd0, control}, 32'h0);
        chk("midrst_set", {24'd0, set}, 32'h0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        ref_cfg = 6'h0; pend_m = 1'b0; prev_m = 1'b0; cnt_m = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(16'h0FF0, 5'd31, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1);

        for (int k = 0; k < 30; k++) begin
            int fp;
            fp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
            run_txn(16'($urandom), 5'($urandom), 1'($urandom), fp, 1'($urandom),
                    8'($urandom_range(1, 255)), 1'b0, 1'b0);
        end

`ifdef TIMER_HOST_IRQ_COUNT_EN
        repeat (70000) begin
            interrupt = 1'b1; @(negedge clk);
            interrupt = 1'b0; @(negedge clk);
        end
        prev_m = 1'b0; pend_m = 1'b1; cnt_m = 16'hFFFF;
        chk("irq_count_sat", {16'd0, irq_count}, 32'h0000FFFF);
        run_txn(16'h5555, 5'd1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("irq_count_clr", {16'd0, irq_count}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
